// File: rtl/div_seq.sv
// ----------------------------------------------------------------------------
// div_seq : multi-cycle radix-2 restoring divider for the execute stage.
//
// Runs DIV (signed) / DIVU (unsigned) over WIDTH iterations while holding the
// pipeline stalled, then presents {remainder, quotient} ({HI, LO}) together
// with a one-cycle ready pulse. Divide-by-zero bypasses the iteration loop.
// A flush (annul) cancels any operation in progress without a ready pulse.
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   synchronous active-low reset
//   alucontrol in   [7:0]  E-stage ALU op (EXE_DIV_OP = signed, else unsigned)
//   start      in   E-stage holds a valid DIV/DIVU (held until stage advances)
//   annul      in   flush / exception, cancels the current operation
//   opdata1    in   [WIDTH-1:0] dividend
//   opdata2    in   [WIDTH-1:0] divisor
//   result     out  [2*WIDTH-1:0] {remainder, quotient}
//   ready      out  result valid, one-cycle pulse in END
//   stall      out  combinational pipeline stall request
// ----------------------------------------------------------------------------
module div_seq #(
  parameter int         WIDTH      = 32,
  parameter logic [7:0] EXE_DIV_OP = 8'b0001_1010
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [7:0]           alucontrol,
  input  logic                 start,
  input  logic                 annul,
  input  logic [WIDTH-1:0]     opdata1,
  input  logic [WIDTH-1:0]     opdata2,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 stall
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  // Two's-complement negate when requested; modulo-2^WIDTH wrap makes the
  // most-negative / -1 case come out as the expected overflow value.
  function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    f_cond_neg = neg ? ((~v) + WIDTH'(1)) : v;
  endfunction

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_ready;

  logic [WIDTH-1:0]     r_rem;     // partial remainder
  logic [WIDTH-1:0]     r_quo;     // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]     r_div;     // divisor magnitude
  logic                 r_neg_q;   // operand signs differ
  logic                 r_neg_r;   // dividend was negative

  logic                 w_signed;
  logic                 w_op1_neg;
  logic                 w_op2_neg;
  logic                 w_div_zero;
  logic [WIDTH-1:0]     w_abs1;
  logic [WIDTH-1:0]     w_abs2;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic                 w_fit;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [WIDTH-1:0]     w_quo_nxt;

  // Anything other than DIV runs unsigned; decode qualifies start.
  assign w_signed   = (alucontrol == EXE_DIV_OP);
  assign w_op1_neg  = w_signed & opdata1[WIDTH-1];
  assign w_op2_neg  = w_signed & opdata2[WIDTH-1];
  assign w_div_zero = (opdata2 == '0);
  assign w_abs1     = f_cond_neg(opdata1, w_op1_neg);
  assign w_abs2     = f_cond_neg(opdata2, w_op2_neg);

  // One restoring step: shift in the next dividend bit, trial-subtract, keep
  // the difference only if it did not borrow.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_fit     = ~w_diff[WIDTH];
  assign w_rem_nxt = w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fit};

  assign stall  = ~annul & (((r_state == S_IDLE) & start) |
                            (r_state == S_ON) | (r_state == S_DIVZERO));
  assign result = r_result;
  assign ready  = r_ready;

  // Datapath registers: no reset, they are always reloaded on a new start.
  // On a zero divisor r_quo keeps the raw dividend for the remainder field.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && start && !annul) begin
      r_rem   <= '0;
      r_quo   <= w_div_zero ? opdata1 : w_abs1;
      r_div   <= w_abs2;
      r_neg_q <= w_op1_neg ^ w_op2_neg;
      r_neg_r <= w_op1_neg;
    end else if (r_state == S_ON) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
    end
  end

  // Control FSM with registered ready/result.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (annul) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_cnt   <= '0;
              r_state <= w_div_zero ? S_DIVZERO : S_ON;
            end
          end
          S_ON: begin
            r_cnt <= r_cnt + CNT_W'(1);
            // Last step: correct signs on the final step values directly.
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_state  <= S_END;
              r_ready  <= 1'b1;
              r_result <= {f_cond_neg(w_rem_nxt, r_neg_r),
                           f_cond_neg(w_quo_nxt, r_neg_q)};
            end
          end
          S_DIVZERO: begin
            r_state  <= S_END;
            r_ready  <= 1'b1;
            r_result <= {r_quo, {WIDTH{1'b1}}};
          end
          // start seen here still belongs to the finished instruction.
          S_END:   r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  localparam int         W       = 32;
  localparam logic [7:0] DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] DIVU_OP = 8'b0001_1011;

  logic             clk = 1'b0;
  logic             resetn;
  logic [7:0]       alucontrol;
  logic             start;
  logic             annul;
  logic [W-1:0]     opdata1;
  logic [W-1:0]     opdata2;
  logic [2*W-1:0]   result;
  logic             ready;
  logic             stall;

  int n_checks = 0;
  int n_pass   = 0;

  div_seq #(.WIDTH(W), .EXE_DIV_OP(DIV_OP)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .alucontrol (alucontrol),
    .start      (start),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: truncating integer division on 64-bit integers.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Issue one division at cycle 0 (caller is at posedge+1), hold start
  // through the END cycle, then release it.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit sgn);
    logic [63:0] exp_res, got_res;
    int exp_lat, rdy_cyc, stall_bad, stall_hi;
    exp_res   = model(a, b, sgn);
    exp_lat   = (b == 32'd0) ? 2 : W + 1;
    rdy_cyc   = -1;
    stall_bad = 0;
    stall_hi  = 0;
    got_res   = '0;
    alucontrol = sgn ? DIV_OP : DIVU_OP;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    for (int c = 0; c < W + 8; c++) begin
      if (c == 1) begin
        opdata1    = $urandom;
        opdata2    = $urandom;
        alucontrol = 8'($urandom);
      end
      mid();
      if (stall === 1'b1) stall_hi++;
      if (stall !== (c < exp_lat)) stall_bad++;
      if (ready === 1'b1) begin
        rdy_cyc = c;
        got_res = result;
        break;
      end
      next_cyc();
    end
    if (rdy_cyc >= 0) next_cyc();
    start = 1'b0;
    mid();
    chk({tag, " ready-pulse"}, 64'(ready), 64'd0);
    next_cyc();
    chk({tag, " latency"}, 64'(rdy_cyc), 64'(exp_lat));
    chk({tag, " stall-pattern"}, 64'(stall_bad), 64'd0);
    chk({tag, " stall-cycles"}, 64'(stall_hi), 64'(exp_lat));
    chk({tag, " result"}, got_res, exp_res);
  endtask

  initial begin
    int n_rdy;
    int rdy_c [2];
    logic [63:0] rdy_r [2];
    logic [31:0] ra, rb;
    bit rs;

    resetn = 1'b0; start = 1'b0; annul = 1'b0;
    alucontrol = '0; opdata1 = '0; opdata2 = '0;
    repeat (3) next_cyc();
    resetn = 1'b1;
    mid();
    chk("reset result", result, 64'd0);
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    next_cyc();

    // annul and start together in IDLE: nothing starts
    alucontrol = DIVU_OP; opdata1 = 32'd5; opdata2 = 32'd1;
    start = 1'b1; annul = 1'b1;
    mid();
    chk("annul+start stall", 64'(stall), 64'd0);
    next_cyc();
    start = 1'b0; annul = 1'b0;
    mid();
    chk("annul+start no-op stall", 64'(stall), 64'd0);
    chk("annul+start no-op ready", 64'(ready), 64'd0);
    next_cyc();

    // directed operations
    do_div("divu 100/7", 32'd100, 32'd7, 1'b0);
    do_div("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_div("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    do_div("divu by zero", 32'h1234, 32'd0, 1'b0);
    do_div("div by zero", 32'h8000_0001, 32'd0, 1'b1);
    do_div("div overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_div("divu ovf operands", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_div("div -max/-max", 32'h8000_0000, 32'h8000_0000, 1'b1);

    // annul in cycle 10 of a running division
    alucontrol = DIVU_OP; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 9) begin
        mid();
        chk("annul pre stall", 64'(stall), 64'd1);
      end
      next_cyc();
    end
    annul = 1'b1;
    mid();
    chk("annul c10 stall", 64'(stall), 64'd0);
    chk("annul c10 ready", 64'(ready), 64'd0);
    next_cyc();
    annul = 1'b0; start = 1'b0;
    mid();
    chk("annul c11 stall", 64'(stall), 64'd0);
    chk("annul c11 ready", 64'(ready), 64'd0);
    next_cyc();
    do_div("after annul 9/3", 32'd9, 32'd3, 1'b0);

    // reset in cycle 20 of a running division
    alucontrol = DIV_OP; opdata1 = 32'hFFFF_FC18; opdata2 = 32'd7; start = 1'b1;
    repeat (20) next_cyc();
    resetn = 1'b0;
    next_cyc();
    resetn = 1'b1; start = 1'b0;
    mid();
    chk("mid-op reset result", result, 64'd0);
    chk("mid-op reset ready", 64'(ready), 64'd0);
    chk("mid-op reset stall", 64'(stall), 64'd0);
    n_rdy = 0;
    for (int c = 0; c < 40; c++) begin
      next_cyc();
      mid();
      if (ready === 1'b1) n_rdy++;
    end
    next_cyc();
    chk("no ready after reset", 64'(n_rdy), 64'd0);

    // back-to-back with start held through END
    alucontrol = DIVU_OP; opdata1 = 32'd1000; opdata2 = 32'd10; start = 1'b1;
    n_rdy = 0;
    rdy_c[0] = -1; rdy_c[1] = -1; rdy_r[0] = '0; rdy_r[1] = '0;
    for (int c = 0; c < 80; c++) begin
      if (c == 34) begin
        alucontrol = DIV_OP; opdata1 = 32'hFFFF_FFCE; opdata2 = 32'd7;
      end
      if (c == 68) start = 1'b0;
      mid();
      if (ready === 1'b1) begin
        if (n_rdy < 2) begin
          rdy_c[n_rdy] = c;
          rdy_r[n_rdy] = result;
        end
        n_rdy++;
      end
      next_cyc();
    end
    chk("b2b ready count", 64'(n_rdy), 64'd2);
    chk("b2b first ready", 64'(rdy_c[0]), 64'd33);
    chk("b2b second ready", 64'(rdy_c[1]), 64'd67);
    chk("b2b first result", rdy_r[0], model(32'd1000, 32'd10, 1'b0));
    chk("b2b second result", rdy_r[1], model(32'hFFFF_FFCE, 32'd7, 1'b1));

    // randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        3:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      rs = 1'($urandom_range(0, 1));
      do_div($sformatf("rand%0d %h/%h s%0d", i, ra, rb, rs), ra, rb, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
